// File: rtl/if_fetch_ctrl_if.sv
// Signal bundle between the fetch sequencing controller, instruction memory and ID-stage logic.
// The master modport is the controller; the slave modport is the memory/pipeline side.
interface if_fetch_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             imem_req;
    logic             imem_ready;
    logic             stall_ID;
    logic             taken_branch1;
    logic             taken_branch2;
    logic [31:0]      branch_target;
    logic             halt_req;
    logic             FREEZE;
    logic             no_new_fetch;
    logic             fetchNull1;
    logic             redirect_o;
    logic [31:0]      redirect_addr_o;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;
    logic [15:0]      squash_count;

    modport master (
        input  imem_ready, stall_ID, taken_branch1, taken_branch2, branch_target, halt_req,
        output imem_req, FREEZE, no_new_fetch, fetchNull1, redirect_o, redirect_addr_o,
               halted, fetch_count, squash_count
    );

    modport slave (
        output imem_ready, stall_ID, taken_branch1, taken_branch2, branch_target, halt_req,
        input  imem_req, FREEZE, no_new_fetch, fetchNull1, redirect_o, redirect_addr_o,
               halted, fetch_count, squash_count
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencing: boot delay, imem req/ready handshake, branch redirect
// hold/apply, stale-response squash, null-slot injection and halt.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BOOT  | post-reset delay, no requests issued
// ST_FETCH | requesting instructions, advancing on accepted responses
// ST_HALT  | fetching stopped, waiting for halt_req to drop
module if_fetch_ctrl #(
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned NULL_SLOTS  = 1,
    parameter int unsigned CNT_W       = 32
) (
    input logic              CLK,
    input logic              RESET,
    if_fetch_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       boot_cnt_q, boot_cnt_d;
    logic             redir_pend_q, redir_pend_d;
    logic [31:0]      pend_addr_q, pend_addr_d;
    logic [1:0]       null_cnt_q, null_cnt_d;
    logic             squash_q, squash_d;
    logic             req_gap_q, req_gap_d;
    logic             redirect_q, redirect_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0]      squash_cnt_q, squash_cnt_d;

    logic req;
    logic retire;
    logic advance;
    logic capture;

    // imem_ready only counts while a request is actually being driven
    assign req     = (state_q == ST_FETCH) && !req_gap_q;
    assign retire  = req && bus.imem_ready;
    assign advance = retire && !bus.halt_req && !squash_q && !bus.stall_ID;
    assign capture = (bus.taken_branch1 || bus.taken_branch2)
                     && (state_q != ST_BOOT) && (state_q != ST_HALT);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= ST_BOOT;
            boot_cnt_q   <= '0;
            redir_pend_q <= 1'b0;
            pend_addr_q  <= '0;
            null_cnt_q   <= '0;
            squash_q     <= 1'b0;
            req_gap_q    <= 1'b0;
            redirect_q   <= 1'b0;
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            boot_cnt_q   <= boot_cnt_d;
            redir_pend_q <= redir_pend_d;
            pend_addr_q  <= pend_addr_d;
            null_cnt_q   <= null_cnt_d;
            squash_q     <= squash_d;
            req_gap_q    <= req_gap_d;
            redirect_q   <= redirect_d;
            fetch_cnt_q  <= fetch_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        boot_cnt_d   = boot_cnt_q;
        redir_pend_d = redir_pend_q;
        pend_addr_d  = pend_addr_q;
        null_cnt_d   = null_cnt_q;
        squash_d     = squash_q;
        req_gap_d    = req_gap_q;
        fetch_cnt_d  = fetch_cnt_q;
        squash_cnt_d = squash_cnt_q;

        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == 8'(BOOT_CYCLES - 1)) begin
                    state_d = ST_FETCH;
                end else begin
                    boot_cnt_d = boot_cnt_q + 8'd1;
                end
            end
            ST_FETCH: begin
                req_gap_d = 1'b0;
                if (bus.halt_req && (!req || bus.imem_ready)) begin
                    // in-flight response (stale or not) is dropped on the way into halt
                    state_d  = ST_HALT;
                    squash_d = 1'b0;
                end else if (squash_q && retire) begin
                    squash_d  = 1'b0;
                    req_gap_d = 1'b1;
                    if (squash_cnt_q != 16'hFFFF) begin
                        squash_cnt_d = squash_cnt_q + 16'd1;
                    end
                end
                if (advance) begin
                    fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
                    if (redirect_q) begin
                        redir_pend_d = 1'b0;
                        null_cnt_d   = 2'(NULL_SLOTS);
                    end else if (null_cnt_q != 2'd0) begin
                        null_cnt_d = null_cnt_q - 2'd1;
                    end
                end
            end
            ST_HALT: begin
                if (!bus.halt_req) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        // a fresh capture wins over the clear of an older redirect applied this cycle
        if (capture) begin
            redir_pend_d = 1'b1;
            pend_addr_d  = bus.branch_target;
            if (req && !bus.imem_ready) begin
                squash_d = 1'b1;
            end
        end
    end

    assign redirect_d = redir_pend_d && (state_d == ST_FETCH) && !squash_d;

    assign bus.imem_req        = req;
    assign bus.FREEZE          = bus.stall_ID;
    assign bus.no_new_fetch    = !advance;
    assign bus.fetchNull1      = (null_cnt_q != 2'd0) && (state_q != ST_BOOT);
    assign bus.redirect_o      = redirect_q;
    assign bus.redirect_addr_o = pend_addr_q;
    assign bus.halted          = (state_q == ST_HALT);
    assign bus.fetch_count     = fetch_cnt_q;
    assign bus.squash_count    = squash_cnt_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with default parameters (BOOT_CYCLES=4, NULL_SLOTS=1).
module tb_if_fetch_ctrl;

    logic CLK;
    logic RESET;
    int   tests_run;
    int   tests_failed;

    if_fetch_ctrl_if bus ();

    if_fetch_ctrl dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " imem_req"}, 32'(bus.imem_req), 32'd0);
        check({tag, " FREEZE"}, 32'(bus.FREEZE), 32'd0);
        check({tag, " no_new_fetch"}, 32'(bus.no_new_fetch), 32'd1);
        check({tag, " fetchNull1"}, 32'(bus.fetchNull1), 32'd0);
        check({tag, " redirect_o"}, 32'(bus.redirect_o), 32'd0);
        check({tag, " redirect_addr"}, bus.redirect_addr_o, 32'd0);
        check({tag, " halted"}, 32'(bus.halted), 32'd0);
        check({tag, " fetch_count"}, bus.fetch_count, 32'd0);
        check({tag, " squash_count"}, 32'(bus.squash_count), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        RESET             = 1'b0;
        bus.imem_ready    = 1'b0;
        bus.stall_ID      = 1'b0;
        bus.taken_branch1 = 1'b0;
        bus.taken_branch2 = 1'b0;
        bus.branch_target = 32'd0;
        bus.halt_req      = 1'b0;
        #2;
        check_reset_outputs("reset");

        // boot: request rises after the 4th edge following release
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("boot%0d imem_req", i), 32'(bus.imem_req), 32'd0);
            check($sformatf("boot%0d no_new_fetch", i), 32'(bus.no_new_fetch), 32'd1);
        end
        step();
        check("boot4 imem_req", 32'(bus.imem_req), 32'd1);

        // streaming: 10 advances
        bus.imem_ready = 1'b1;
        #1;
        check("stream no_new_fetch", 32'(bus.no_new_fetch), 32'd0);
        for (int i = 0; i < 10; i++) step();
        check("stream fetch_count", bus.fetch_count, 32'd10);
        check("stream fetchNull1", 32'(bus.fetchNull1), 32'd0);

        // stall for 3 cycles with response held
        bus.stall_ID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall FREEZE", 32'(bus.FREEZE), 32'd1);
            check("stall no_new_fetch", 32'(bus.no_new_fetch), 32'd1);
            step();
            check("stall fetch_count", bus.fetch_count, 32'd10);
        end
        bus.stall_ID = 1'b0;
        #1;
        check("unstall FREEZE", 32'(bus.FREEZE), 32'd0);
        step();
        check("resume fetch_count", bus.fetch_count, 32'd11);

        // branch while request outstanding -> squash
        bus.imem_ready    = 1'b0;
        bus.taken_branch2 = 1'b1;
        bus.branch_target = 32'h0000_0040;
        step();
        bus.taken_branch2 = 1'b0;
        check("squash redirect_o held", 32'(bus.redirect_o), 32'd0);
        step();
        step();
        bus.imem_ready = 1'b1;
        step();
        check("squash squash_count", 32'(bus.squash_count), 32'd1);
        check("squash imem_req gap", 32'(bus.imem_req), 32'd0);
        check("squash gap no_new_fetch", 32'(bus.no_new_fetch), 32'd1);
        check("squash gap fetch_count", bus.fetch_count, 32'd11);
        step();
        check("squash req back", 32'(bus.imem_req), 32'd1);
        check("squash redirect_o", 32'(bus.redirect_o), 32'd1);
        check("squash redirect_addr", bus.redirect_addr_o, 32'h0000_0040);
        check("squash advance", 32'(bus.no_new_fetch), 32'd0);
        step();
        check("redir fetch_count", bus.fetch_count, 32'd12);
        check("redir redirect_o clr", 32'(bus.redirect_o), 32'd0);
        check("redir fetchNull1", 32'(bus.fetchNull1), 32'd1);
        step();
        check("null done fetchNull1", 32'(bus.fetchNull1), 32'd0);
        check("null done fetch_count", bus.fetch_count, 32'd13);

        // dual branch while stalled -> one pending redirect, no squash
        bus.stall_ID      = 1'b1;
        bus.taken_branch1 = 1'b1;
        bus.taken_branch2 = 1'b1;
        bus.branch_target = 32'h0000_0080;
        step();
        bus.taken_branch1 = 1'b0;
        bus.taken_branch2 = 1'b0;
        check("dual redirect_o", 32'(bus.redirect_o), 32'd1);
        check("dual redirect_addr", bus.redirect_addr_o, 32'h0000_0080);
        check("dual squash_count", 32'(bus.squash_count), 32'd1);
        step();
        check("dual stalled fetch_count", bus.fetch_count, 32'd13);
        bus.stall_ID = 1'b0;
        #1;
        check("dual advance", 32'(bus.no_new_fetch), 32'd0);
        step();
        check("dual fetch_count", bus.fetch_count, 32'd14);
        check("dual redirect_o clr", 32'(bus.redirect_o), 32'd0);
        check("dual fetchNull1", 32'(bus.fetchNull1), 32'd1);
        step();
        check("dual null done", 32'(bus.fetchNull1), 32'd0);
        check("dual fetch_count2", bus.fetch_count, 32'd15);

        // halt with request outstanding
        bus.imem_ready = 1'b0;
        bus.halt_req   = 1'b1;
        step();
        check("halt wait halted", 32'(bus.halted), 32'd0);
        check("halt wait imem_req", 32'(bus.imem_req), 32'd1);
        step();
        bus.imem_ready = 1'b1;
        #1;
        check("halt retire no_new_fetch", 32'(bus.no_new_fetch), 32'd1);
        step();
        check("halt halted", 32'(bus.halted), 32'd1);
        check("halt imem_req", 32'(bus.imem_req), 32'd0);
        check("halt fetch_count", bus.fetch_count, 32'd15);
        bus.taken_branch1 = 1'b1;
        bus.branch_target = 32'h0000_0200;
        step();
        bus.taken_branch1 = 1'b0;
        check("halt branch ignored", 32'(bus.redirect_o), 32'd0);
        bus.halt_req = 1'b0;
        step();
        check("unhalt imem_req", 32'(bus.imem_req), 32'd1);
        check("unhalt halted", 32'(bus.halted), 32'd0);
        check("unhalt redirect_o", 32'(bus.redirect_o), 32'd0);
        step();
        check("unhalt fetch_count", bus.fetch_count, 32'd16);

        // reset in the middle of a squash
        bus.imem_ready    = 1'b0;
        bus.taken_branch1 = 1'b1;
        bus.branch_target = 32'h0000_0100;
        step();
        bus.taken_branch1 = 1'b0;
        check("presquash redirect_addr", bus.redirect_addr_o, 32'h0000_0100);
        RESET = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge CLK);
        RESET          = 1'b1;
        bus.imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("postreset imem_req", 32'(bus.imem_req), 32'd1);
        check("postreset redirect_o", 32'(bus.redirect_o), 32'd0);
        step();
        check("postreset fetch_count", bus.fetch_count, 32'd1);
        check("postreset squash_count", 32'(bus.squash_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
